delay_sum_beamformer: RTL and testbench

Parametrised delay-and-sum beamformer for multiple I2S stereo microphone lines. It generates the I2S word select and deserialises every line into 2*NUM_MICS signed PCM channels. Each channel has its own delay line with a runtime-programmable tap, and the block averages the selected taps. The result is emitted as a mono I2S stream on both slots and as a parallel PCM word with a valid strobe.

---
 rtl/delay_sum_beamformer.sv | 190 +++++++++++++++++++
 tb/tb_delay_sum_beamformer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: deserialises NUM_MICS I2S stereo lines, averages per-channel delayed taps,
// and emits the result as mono I2S plus parallel PCM. Optional macro BEAMFORMER_CHANNEL_MASK_EN adds a channel mask.
module delay_sum_beamformer #(
    parameter int unsigned NUM_MICS    = 4,
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned DELAY_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_MICS-1:0]              sd_in,
    output logic                             ws_out,
    output logic                             sd_out,
    input  logic                             cfg_we,
    input  logic [$clog2(2*NUM_MICS)-1:0]    cfg_addr,
    input  logic [$clog2(DELAY_DEPTH)-1:0]   cfg_delay,
`ifdef BEAMFORMER_CHANNEL_MASK_EN
    input  logic                             cfg_mask_we,
`endif
    output logic [SAMPLE_BITS-1:0]           pcm_out,
    output logic                             pcm_valid
);
    localparam int unsigned CH = 2 * NUM_MICS;
    localparam int unsigned CW = $clog2(CH);
    localparam int unsigned DW = $clog2(DELAY_DEPTH);
    localparam int unsigned AW = SAMPLE_BITS + CW;
    localparam int unsigned FL = 2 * SLOT_BITS;
    localparam int unsigned FW = $clog2(FL);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_e;

    state_e                 state_q, state_d;
    logic [FW-1:0]          fc_q, fc_d;
    logic                   ws_q, ws_d;
    logic                   sd_q, sd_d;
    logic [SAMPLE_BITS-1:0] tx_q, tx_d;
    logic [SAMPLE_BITS-1:0] pcm_q, pcm_d;
    logic                   valid_q, valid_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [SAMPLE_BITS-1:0] sr_q     [CH];
    logic [SAMPLE_BITS-1:0] sr_d     [CH];
    logic [SAMPLE_BITS-1:0] dl_q     [CH][DELAY_DEPTH];
    logic [SAMPLE_BITS-1:0] dl_d     [CH][DELAY_DEPTH];
    logic [DW-1:0]          shadow_q [CH];
    logic [DW-1:0]          shadow_d [CH];
    logic [DW-1:0]          act_q    [CH];
    logic [DW-1:0]          act_d    [CH];

    logic                   push, capture;
    logic                   acc_clr, acc_add, pcm_load;
    logic [FW-1:0]          slot_idx, slot_nxt;
    logic [SAMPLE_BITS-1:0] sel_tap;
    logic [AW-1:0]          tap_ext;
    logic [CH-1:0]          chan_en;

`ifdef BEAMFORMER_CHANNEL_MASK_EN
    logic [CH-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        for (int c = 0; c < CH; c++) begin
            if (cfg_mask_we && (cfg_addr == CW'(c))) mask_d[c] = cfg_delay[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mask_q <= '1;
        else       mask_q <= mask_d;
    end

    assign chan_en = mask_q;
`else
    assign chan_en = '1;
`endif

    // Frame counter, slot position and word select
    always_comb begin
        push     = (fc_q == FW'(FL - 1));
        fc_d     = push ? '0 : fc_q + FW'(1);
        slot_idx = (fc_q >= FW'(SLOT_BITS)) ? fc_q - FW'(SLOT_BITS) : fc_q;
        slot_nxt = (fc_d >= FW'(SLOT_BITS)) ? fc_d - FW'(SLOT_BITS) : fc_d;
        ws_d     = (fc_d >= FW'(SLOT_BITS));
        capture  = (slot_idx != '0) && (slot_idx <= FW'(SAMPLE_BITS));
    end

    // Deserialisers, delay lines and shadow/active tap registers
    always_comb begin
        sr_d     = sr_q;
        dl_d     = dl_q;
        shadow_d = shadow_q;
        act_d    = act_q;
        for (int c = 0; c < CH; c++) begin
            if (capture && (ws_q == 1'(c & 1))) sr_d[c] = {sr_q[c][SAMPLE_BITS-2:0], sd_in[c >> 1]};
            if (cfg_we && (cfg_addr == CW'(c))) shadow_d[c] = cfg_delay;
        end
        if (push) begin
            act_d = shadow_d;
            for (int c = 0; c < CH; c++) begin
                dl_d[c][0] = sr_q[c];
                for (int t = 1; t < DELAY_DEPTH; t++) dl_d[c][t] = dl_q[c][t-1];
            end
        end
    end

    // Channel fc selects its active tap; out-of-range taps and masked channels read 0
    always_comb begin
        sel_tap = '0;
        for (int c = 0; c < CH; c++) begin
            for (int t = 0; t < DELAY_DEPTH; t++) begin
                if ((fc_q == FW'(c)) && (act_q[c] == DW'(t)) && chan_en[c]) sel_tap = dl_q[c][t];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fc_q == '0) state_d = ACC;
            ACC:     if (fc_q == FW'(CH - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: IDLE at fc=0 seeds the sum with channel 0, ACC adds channels 1..CH-1
    always_comb begin
        acc_clr  = (state_q == IDLE) && (fc_q == '0);
        acc_add  = (state_q == ACC);
        pcm_load = (state_q == DONE);
    end

    // Accumulator, PCM result and serial transmitter
    always_comb begin
        tap_ext = {{CW{sel_tap[SAMPLE_BITS-1]}}, sel_tap};
        acc_d   = acc_q;
        if (acc_clr)      acc_d = tap_ext;
        else if (acc_add) acc_d = acc_q + tap_ext;
        // Dropping the low CW bits is the arithmetic shift by CW truncated to SAMPLE_BITS
        pcm_d   = pcm_load ? acc_q[AW-1:CW] : pcm_q;
        valid_d = pcm_load;
        tx_d    = (fc_q == '0) ? pcm_q : tx_q;
        sd_d    = 1'b0;
        for (int b = 0; b < SAMPLE_BITS; b++) begin
            if (slot_nxt == FW'(b + 1)) sd_d = tx_d[SAMPLE_BITS-1-b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fc_q    <= '0;
            ws_q    <= 1'b0;
            sd_q    <= 1'b0;
            tx_q    <= '0;
            pcm_q   <= '0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            for (int c = 0; c < CH; c++) begin
                sr_q[c]     <= '0;
                shadow_q[c] <= '0;
                act_q[c]    <= '0;
                for (int t = 0; t < DELAY_DEPTH; t++) dl_q[c][t] <= '0;
            end
        end else begin
            fc_q     <= fc_d;
            ws_q     <= ws_d;
            sd_q     <= sd_d;
            tx_q     <= tx_d;
            pcm_q    <= pcm_d;
            valid_q  <= valid_d;
            acc_q    <= acc_d;
            sr_q     <= sr_d;
            dl_q     <= dl_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
        end
    end

    assign ws_out    = ws_q;
    assign sd_out    = sd_q;
    assign pcm_out   = pcm_q;
    assign pcm_valid = valid_q;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Self-checking bench for delay_sum_beamformer (2 mics, 16-bit samples, 32-cycle slots, 8-deep delay lines).
module tb_delay_sum_beamformer;
    localparam int FL = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sd_in = '0;
    logic        ws_out, sd_out;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [2:0]  cfg_delay = '0;
    logic [15:0] pcm_out;
    logic        pcm_valid;

    delay_sum_beamformer #(
        .NUM_MICS(2), .SAMPLE_BITS(16), .SLOT_BITS(32), .DELAY_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .sd_in(sd_in), .ws_out(ws_out), .sd_out(sd_out),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay),
        .pcm_out(pcm_out), .pcm_valid(pcm_valid)
    );

    always #5 clk = ~clk;

    // Reference model: frame position, sample history, shadow/active delays, expected outputs
    int          fc_m, fr;
    logic [15:0] hist [16][4];
    logic [15:0] frame_smp [4];
    bit          rand_smp;
    int          sh [4];
    int          act [4];
    logic [15:0] pcm_m, tx_m;
    int          nvec, nerr;
    int          hits, hit_fr, imp_fr;

    function automatic logic [15:0] model_avg();
        int sum = 0;
        for (int c = 0; c < 4; c++) begin
            int k = fr - 1 - act[c];
            if (k >= 0) sum += int'($signed(hist[k % 16][c]));
        end
        return 16'(sum >>> 2);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s frame=%0d fc=%0d observed=%h expected=%h", tag, fr, fc_m, obs, exp);
        end
    endtask

    task automatic model_reset();
        fc_m = 0; fr = 0; pcm_m = '0; tx_m = '0;
        for (int c = 0; c < 4; c++) begin
            sh[c] = 0; act[c] = 0;
            for (int f = 0; f < 16; f++) hist[f][c] = '0;
        end
    endtask

    // One clock: drive the inputs for the current frame position, advance the model, check all outputs
    task automatic tick();
        int s;
        if (fc_m == 0) begin
            if (rand_smp) for (int c = 0; c < 4; c++) frame_smp[c] = 16'($urandom);
            for (int c = 0; c < 4; c++) hist[fr % 16][c] = frame_smp[c];
        end
        s = fc_m % 32;
        for (int m = 0; m < 2; m++) begin
            if (s >= 1 && s <= 16) sd_in[m] = hist[fr % 16][2*m + ((fc_m >= 32) ? 1 : 0)][16 - s];
            else                   sd_in[m] = 1'($urandom);
        end
        if (!reset) begin
            if (cfg_we) sh[cfg_addr] = int'(cfg_delay);
            if (fc_m == FL - 1) act = sh;
        end
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else begin
            if (fc_m == FL - 1) begin fc_m = 0; fr++; end
            else fc_m++;
            if (fc_m == 5) pcm_m = model_avg();
            if (fc_m == 1) tx_m = pcm_m;
        end
        s = fc_m % 32;
        chk("ws_out", 16'(ws_out), 16'(fc_m >= 32));
        chk("pcm_valid", 16'(pcm_valid), 16'(fc_m == 5));
        chk("pcm_out", pcm_out, pcm_m);
        chk("sd_out", 16'(sd_out), (s >= 1 && s <= 16) ? 16'(tx_m[16 - s]) : 16'd0);
        if (pcm_valid === 1'b1 && pcm_out === 16'h1000) begin hits++; hit_fr = fr; end
    endtask

    task automatic run_to_fc(input int target);
        for (int i = 0; i < FL && fc_m != target; i++) tick();
    endtask

    task automatic run_frames(input int n);
        repeat (n * FL) tick();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [2:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_delay = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic set_smp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        frame_smp[0] = a; frame_smp[1] = b; frame_smp[2] = c; frame_smp[3] = d;
    endtask

    initial begin
        nvec = 0; nerr = 0; hits = 0; hit_fr = -1; imp_fr = 0;
        rand_smp = 1'b0;
        set_smp(16'h0, 16'h0, 16'h0, 16'h0);
        model_reset();

        // Reset for three cycles, then idle with silent inputs
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (200) tick();

        // Constant 0x1000 on every channel, all delays 0
        set_smp(16'h1000, 16'h1000, 16'h1000, 16'h1000);
        run_frames(4);
        chk("const_1000", pcm_out, 16'h1000);

        // Single impulse on channel 0 with a 3-frame delay
        set_smp(16'h0, 16'h0, 16'h0, 16'h0);
        cfg_write(2'd0, 3'd3);
        run_frames(9);
        run_to_fc(0);
        frame_smp[0] = 16'h4000;
        imp_fr = fr;
        hits = 0; hit_fr = -1;
        tick();
        frame_smp[0] = 16'h0;
        run_frames(7);
        chk("impulse_hits", 16'(hits), 16'd1);
        chk("impulse_frame", 16'(hit_fr), 16'(imp_fr + 4));

        // Full-scale negative and mixed extremes
        cfg_write(2'd0, 3'd0);
        run_frames(2);
        set_smp(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        run_frames(3);
        chk("all_8000", pcm_out, 16'h8000);
        set_smp(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000);
        run_frames(3);
        chk("mixed_sum_neg2", pcm_out, 16'hFFFF);

        // Config write landing on the push cycle is committed with it
        rand_smp = 1'b1;
        run_to_fc(FL - 1);
        cfg_write(2'd1, 3'd2);
        run_frames(4);

        // Randomised samples with sporadic delay writes
        repeat (15 * FL) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg_we = 1'b1; cfg_addr = 2'($urandom); cfg_delay = 3'($urandom);
            end else cfg_we = 1'b0;
            tick();
        end
        cfg_we = 1'b0;

        // Reset in mid-frame clears everything including programmed delays
        run_to_fc(40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_ws", 16'(ws_out), 16'd0);
        chk("rst_sd", 16'(sd_out), 16'd0);
        chk("rst_pcm", pcm_out, 16'h0);
        chk("rst_valid", 16'(pcm_valid), 16'd0);
        run_frames(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
